stream_cipher_host: RTL and testbench

STREAM_CIPHER_HOST -- requirements
Module: stream_cipher_host

---
 rtl/stream_cipher_pkg.sv | 6 +
 rtl/stream_cipher_if.sv | 24 ++
 rtl/handshake_timer.sv | 16 +
 rtl/stream_cipher_host.sv | 67 ++++++
 tb/tb_stream_cipher_host.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_cipher_pkg.sv
// stream_cipher_pkg: shared host state encoding and default sizing constants
package stream_cipher_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_TIMEOUT_CYCLES = 255;
  typedef enum logic [1:0] {H_IDLE, H_REQUEST, H_ACK, H_DELIVER} host_state_e;
endpackage

// File: rtl/stream_cipher_if.sv
// stream_cipher_if: local request/response streams plus the cipher chip handshake pins
interface stream_cipher_if import stream_cipher_pkg::*; #(parameter int DATA_W = DEF_DATA_W);
  logic req_valid;
  logic req_ready;
  logic [DATA_W-1:0] req_data;
  logic input_request;
  logic [DATA_W-1:0] chip_data_out;
  logic chip_done;
  logic [DATA_W-1:0] chip_data_in;
  logic output_acknowledge;
  logic rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic rsp_ready;
  logic timeout_err;
  logic [15:0] txn_count;
  modport master (
    output req_valid, req_data, chip_done, chip_data_in, rsp_ready,
    input  req_ready, input_request, chip_data_out, output_acknowledge, rsp_valid, rsp_data, timeout_err, txn_count
  );
  modport slave (
    input  req_valid, req_data, chip_done, chip_data_in, rsp_ready,
    output req_ready, input_request, chip_data_out, output_acknowledge, rsp_valid, rsp_data, timeout_err, txn_count
  );
endinterface

// File: rtl/handshake_timer.sv
// handshake_timer: saturating wait counter flagging when a handshake phase has waited LIMIT cycles
module handshake_timer #(parameter int LIMIT = 255) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (enable && !expired) cnt <= cnt + W'(1);
  end
  assign expired = cnt == W'(LIMIT);
endmodule

// File: rtl/stream_cipher_host.sv
// stream_cipher_host: sequences one plaintext word at a time through the external cipher chip
module stream_cipher_host import stream_cipher_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic clk,
  input logic rst,
  stream_cipher_if.slave bus
);
  host_state_e state, state_n;
  logic [DATA_W-1:0] pt_q, ct_q;
  logic [15:0] txn_q;
  logic ir_q, oa_q, to_q;
  logic accept, expired, to_fire;
  assign accept = state == H_IDLE && bus.req_valid && !bus.chip_done;
  handshake_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .clear(state_n != state),
    .enable(state == H_REQUEST || state == H_ACK),
    .expired(expired)
  );
  always_comb begin
    state_n = state;
    to_fire = 1'b0;
    case (state)
      H_IDLE:    state_n = accept ? H_REQUEST : H_IDLE;
      H_REQUEST: begin
        to_fire = !bus.chip_done && expired;
        state_n = bus.chip_done ? H_ACK : expired ? H_IDLE : H_REQUEST;
      end
      H_ACK:     begin
        to_fire = bus.chip_done && expired;
        state_n = !bus.chip_done ? H_DELIVER : expired ? H_IDLE : H_ACK;
      end
      H_DELIVER: state_n = bus.rsp_ready ? H_IDLE : H_DELIVER;
      default:   state_n = H_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= H_IDLE;
      ir_q <= 1'b0;
      oa_q <= 1'b0;
      to_q <= 1'b0;
      pt_q <= '0;
      ct_q <= '0;
      txn_q <= '0;
    end else begin
      state <= state_n;
      ir_q <= state_n == H_REQUEST;
      oa_q <= state_n == H_ACK;
      to_q <= to_fire;
      if (accept) pt_q <= bus.req_data;
      if (state == H_REQUEST && bus.chip_done) ct_q <= bus.chip_data_in;
      if (state == H_DELIVER && bus.rsp_ready) txn_q <= txn_q + 16'd1;
    end
  end
  assign bus.req_ready = state == H_IDLE && !bus.chip_done;
  assign bus.input_request = ir_q;
  assign bus.chip_data_out = pt_q;
  assign bus.output_acknowledge = oa_q;
  assign bus.rsp_valid = state == H_DELIVER;
  assign bus.rsp_data = ct_q;
  assign bus.timeout_err = to_q;
  assign bus.txn_count = txn_q;
endmodule

// File: tb/tb_stream_cipher_host.sv
// tb_stream_cipher_host: table, directed and random transactions against a behavioural chip and host model
module tb_stream_cipher_host;
  localparam int DW = 8;
  localparam int TO = 8;
  typedef struct {
    logic [7:0] pt;
    logic [7:0] key;
    int d;
    int a;
    int bp;
    logic [7:0] ct;
    int lat;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  stream_cipher_if #(.DATA_W(DW)) bus ();
  stream_cipher_host #(.DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int failures = 0;
  int to_pulses = 0;
  int rv_seen = 0;
  logic [15:0] model_cnt = 16'd0;
  bit chip_hang = 1'b0;
  bit chip_manual = 1'b0;
  bit chip_manual_done = 1'b0;
  int chip_dly = 1;
  int ack_dly = 1;
  logic [7:0] chip_key = 8'h00;
  int chip_rc = 0;
  int chip_ac = 0;
  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Chip model: raises done d cycles after it registers input_request, drops it a cycles after acknowledge.
  initial begin
    bus.chip_done = 1'b0;
    bus.chip_data_in = '0;
    forever begin
      @(negedge clk);
      if (chip_manual) begin
        bus.chip_done = chip_manual_done;
        chip_rc = 0;
        chip_ac = 0;
      end else if (rst) begin
        bus.chip_done = 1'b0;
        chip_rc = 0;
        chip_ac = 0;
      end else begin
        chip_rc = bus.input_request ? chip_rc + 1 : 0;
        chip_ac = bus.output_acknowledge ? chip_ac + 1 : 0;
        if (!chip_hang && bus.input_request && chip_rc == chip_dly + 1) begin
          bus.chip_done = 1'b1;
          bus.chip_data_in = bus.chip_data_out ^ chip_key;
        end
        if (bus.output_acknowledge && chip_ac == ack_dly + 1) bus.chip_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.timeout_err) to_pulses++;
    if (bus.rsp_valid) rv_seen++;
    if (!rst) begin
      checks++;
      if (bus.input_request && bus.output_acknowledge) begin
        failures++;
        $display("FAIL req_ack_overlap: got both=1 expected at most one");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_txn(input logic [7:0] pt, input logic [7:0] key, input int d, input int a,
                         input int bp, input logic [7:0] exp_ct, input int exp_lat);
    int lat, irc, oac;
    chip_key = key;
    chip_dly = d;
    ack_dly = a;
    bus.req_valid = 1'b1;
    bus.req_data = pt;
    chk("req_ready_idle", 32'(bus.req_ready), 1);
    tick();
    bus.req_valid = 1'b0;
    chk("req_ready_busy", 32'(bus.req_ready), 0);
    lat = 0;
    irc = 0;
    oac = 0;
    while (!bus.rsp_valid && lat < 60) begin
      irc += 32'(bus.input_request);
      oac += 32'(bus.output_acknowledge);
      tick();
      lat++;
    end
    chk("rsp_valid_arrives", 32'(bus.rsp_valid), 1);
    chk("latency", lat, exp_lat);
    chk("input_request_cycles", irc, d + 1);
    chk("ack_cycles", oac, a + 1);
    repeat (bp) begin
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("bp_rsp_data", 32'(bus.rsp_data), 32'(exp_ct));
      chk("bp_txn_count", 32'(bus.txn_count), 32'(model_cnt));
      tick();
    end
    chk("rsp_data", 32'(bus.rsp_data), 32'(exp_ct));
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    model_cnt = model_cnt + 16'd1;
    chk("txn_count", 32'(bus.txn_count), 32'(model_cnt));
    chk("rsp_valid_after_accept", 32'(bus.rsp_valid), 0);
    chk("req_ready_after_accept", 32'(bus.req_ready), 1);
  endtask

  initial begin
    int n, irc, p0, rv0;
    logic [7:0] pt, key;
    int d, a;
    bus.req_valid = 1'b0;
    bus.req_data = '0;
    bus.rsp_ready = 1'b0;
    vt[0] = '{8'h3C, 8'h99, 1, 1, 0, 8'hA5, 4};
    vt[1] = '{8'h3C, 8'h99, 1, 1, 5, 8'hA5, 4};
    vt[2] = '{8'h00, 8'hFF, 1, 1, 0, 8'hFF, 4};
    vt[3] = '{8'hFF, 8'h0F, 3, 2, 1, 8'hF0, 7};
    vt[4] = '{8'h55, 8'hAA, 5, 1, 2, 8'hFF, 8};
    vt[5] = '{8'h81, 8'h18, 2, 4, 0, 8'h99, 8};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_input_request", 32'(bus.input_request), 0);
    chk("rst_output_ack", 32'(bus.output_acknowledge), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_timeout_err", 32'(bus.timeout_err), 0);
    chk("rst_txn_count", 32'(bus.txn_count), 0);
    chk("rst_chip_data_out", 32'(bus.chip_data_out), 0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 6; i++)
      run_txn(vt[i].pt, vt[i].key, vt[i].d, vt[i].a, vt[i].bp, vt[i].ct, vt[i].lat);
    // Chip never answers: exactly one timeout pulse and no delivery.
    chip_hang = 1'b1;
    p0 = to_pulses;
    rv0 = rv_seen;
    bus.req_valid = 1'b1;
    bus.req_data = 8'h11;
    tick();
    bus.req_valid = 1'b0;
    irc = 0;
    n = 0;
    while (!bus.timeout_err && n < 40) begin
      irc += 32'(bus.input_request);
      tick();
      n++;
    end
    chk("timeout_err_seen", 32'(bus.timeout_err), 1);
    chk("timeout_ir_window", 32'(irc >= TO && irc <= TO + 2), 1);
    chk("timeout_ir_low", 32'(bus.input_request), 0);
    chk("timeout_ack_low", 32'(bus.output_acknowledge), 0);
    repeat (3) tick();
    chk("timeout_pulse_count", to_pulses - p0, 1);
    chk("timeout_no_rsp", rv_seen - rv0, 0);
    chk("timeout_txn_count", 32'(bus.txn_count), 32'(model_cnt));
    chk("timeout_back_idle", 32'(bus.req_ready), 1);
    chip_hang = 1'b0;
    // Stale done while idle blocks new requests until it drops.
    chip_manual_done = 1'b1;
    chip_manual = 1'b1;
    tick();
    bus.req_valid = 1'b1;
    bus.req_data = 8'h77;
    repeat (4) begin
      chk("stale_req_ready", 32'(bus.req_ready), 0);
      chk("stale_input_request", 32'(bus.input_request), 0);
      tick();
    end
    bus.req_valid = 1'b0;
    chip_manual_done = 1'b0;
    tick();
    chip_manual = 1'b0;
    chk("stale_cleared_ready", 32'(bus.req_ready), 1);
    run_txn(8'h77, 8'h42, 1, 1, 0, 8'h35, 4);
    // Reset while acknowledging aborts without a timeout pulse.
    chip_key = 8'h0F;
    chip_dly = 1;
    ack_dly = 20;
    bus.req_valid = 1'b1;
    bus.req_data = 8'h5A;
    tick();
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.output_acknowledge && n < 20) begin
      tick();
      n++;
    end
    chk("midack_reached", 32'(bus.output_acknowledge), 1);
    p0 = to_pulses;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midack_rst_ir", 32'(bus.input_request), 0);
    chk("midack_rst_ack", 32'(bus.output_acknowledge), 0);
    chk("midack_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("midack_rst_timeout", 32'(bus.timeout_err), 0);
    chk("midack_rst_txn", 32'(bus.txn_count), 0);
    @(negedge clk);
    rst = 1'b0;
    model_cnt = 16'd0;
    ack_dly = 1;
    repeat (12) tick();
    chk("midack_no_timeout", to_pulses - p0, 0);
    chk("midack_idle_ready", 32'(bus.req_ready), 1);
    for (int i = 0; i < 20; i++) begin
      pt = 8'($urandom);
      key = 8'($urandom);
      d = int'($urandom_range(1, 4));
      a = int'($urandom_range(1, 4));
      run_txn(pt, key, d, a, int'($urandom_range(0, 3)), pt ^ key, d + a + 2);
    end
    force dut.txn_q = 16'hFFFF;
    tick();
    release dut.txn_q;
    model_cnt = 16'hFFFF;
    chk("wrap_preload", 32'(bus.txn_count), 32'hFFFF);
    run_txn(8'hC3, 8'h3C, 1, 1, 0, 8'hFF, 4);
    chk("wrap_zero", 32'(bus.txn_count), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
